counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 SHALL have parameter MAX_POS, default 15, the upper position limit for step commands (0..15).
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port CLR_N  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports A_VALID, B_VALID  input  1 each  requester A/B command valid.
REQ-005 SHALL have ports A_OP, B_OP  input  2 each  opcode: 00 clear, 01 step up, 10 step down, 11 load.
REQ-006 SHALL have ports A_ARG, B_ARG  input  4 each  step count (step ops) or load value (load op).
REQ-007 SHALL have ports A_READY, B_READY  output  1 each  command accepted this cycle when VALID and READY are both high.
REQ-008 SHALL have ports increase, decrease, parallel, CLR  output  1 each  single-cycle strobes to the counter datapath.
REQ-009 SHALL have port load  output  4  parallel load value; qualified by parallel.
REQ-010 SHALL have ports POS  output  4  shadow copy of counter position.
REQ-011 SHALL have ports BUSY, DONE, DONE_ID, SAT  output  1 each  busy, completion pulse, completing requester (0=A, 1=B), saturation flag.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, FIN.
REQ-013 In IDLE, SHALL assert READY to at most one requester; sole valid requester wins; if both valid, the requester not granted last wins (round-robin; A wins first contest after reset).
REQ-014 SHALL capture op, arg and requester id on acceptance (cycle T) and move to EXEC; VALID without READY SHALL have no effect.
REQ-015 READY SHALL be low outside IDLE; BUSY SHALL be high in EXEC and FIN.
REQ-016 Clear: CLR strobe one cycle at T+1, POS becomes 0, then FIN.
REQ-017 Load: parallel strobe one cycle at T+1 with load = captured arg, POS becomes arg, then FIN; arg above MAX_POS SHALL be clamped to MAX_POS.
REQ-018 Step up N: one increase strobe per cycle from T+1, POS +1 each, stopping after N strobes or when POS = MAX_POS, whichever first.
REQ-019 Step down N: one decrease strobe per cycle from T+1, POS -1 each, stopping after N strobes or when POS = 0.
REQ-020 Step with N=0 SHALL issue no strobe and go directly to FIN at T+1.
REQ-021 SHALL never wrap: no increase strobe at POS = MAX_POS, no decrease strobe at POS = 0.
REQ-022 SAT SHALL be set at completion if a step stopped before N strobes or a load was clamped; cleared at next acceptance.
REQ-023 At most one of increase, decrease, parallel, CLR SHALL be high in any cycle; all low in IDLE and FIN.
REQ-024 FIN SHALL last one cycle with DONE high and DONE_ID = captured id, then return to IDLE; next acceptance earliest in cycle after FIN.
REQ-025 Counter-side latency: strobe at cycle k reflected in POS at cycle k+1.

Reset
REQ-026 CLR_N low SHALL immediately force state IDLE, POS 0, all strobes, READY, DONE, BUSY, SAT, DONE_ID low, load 0, round-robin pointer to favour A.
REQ-027 Reset mid-EXEC SHALL abandon the command with no DONE pulse; no strobe after CLR_N falls.
REQ-028 After CLR_N rises, first acceptance SHALL be possible in the first clock cycle.

Verification
REQ-029 Reset, A: op 01 arg 3 -> increase high 3 consecutive cycles, POS 0->3, DONE with DONE_ID 0, SAT 0.
REQ-030 POS 13, B: op 01 arg 5 (MAX_POS 15) -> exactly 2 increase strobes, POS 15, SAT 1, DONE_ID 1.
REQ-031 A and B valid simultaneously twice in a row -> A served first, B second; READY never high on both.
REQ-032 A: op 11 arg 9 -> parallel one cycle, load 9, POS 9; then op 10 arg 12 -> 9 decrease strobes, POS 0, SAT 1.
REQ-033 CLR_N low during 4th strobe of step-up 8 -> strobes stop immediately, POS 0, no DONE; next command accepted after release.
REQ-034 Step op arg 0 -> no strobe, DONE one cycle after acceptance, POS unchanged.

Source files
------------

// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler that turns clear/step/load commands into
// single-cycle strobes for a saturating 0..MAX_POS counter, keeping a shadow position.
module counter_sched #(
   parameter int MAX_POS = 15
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       A_VALID,
   input  logic       B_VALID,
   input  logic [1:0] A_OP,
   input  logic [1:0] B_OP,
   input  logic [3:0] A_ARG,
   input  logic [3:0] B_ARG,
   output logic       A_READY,
   output logic       B_READY,
   output logic       increase,
   output logic       decrease,
   output logic       parallel,
   output logic       CLR,
   output logic [3:0] load,
   output logic [3:0] POS,
   output logic       BUSY,
   output logic       DONE,
   output logic       DONE_ID,
   output logic       SAT
);

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   localparam logic [3:0] MAX_V  = 4'(MAX_POS);
   localparam logic [3:0] MAX_M1 = MAX_V - 4'd1;
   localparam logic [4:0] MAX_W  = 5'(MAX_POS);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      FIN
   } state_t;

   state_t     state;
   state_t     state_next;
   logic       prefer_b;
   logic [1:0] cur_op;
   logic [3:0] cur_arg;
   logic       cur_id;
   logic [3:0] pos;
   logic       sat;

   logic       grant_a;
   logic       grant_b;
   logic       accept;
   logic [1:0] acc_op;
   logic [3:0] acc_arg;
   logic       acc_zero_step;
   logic       clamped;
   logic [3:0] load_val;
   logic       at_top;
   logic       at_bot;

   logic       inc_s;
   logic       dec_s;
   logic       par_s;
   logic       clr_s;
   logic       fin_sat;

   // Arbitration: prefer_b flips to the other requester after every grant,
   // so when both are valid the one not served last goes first.
   always_comb begin
      grant_a = (state == IDLE) && A_VALID && (!B_VALID || !prefer_b);
      grant_b = (state == IDLE) && B_VALID && !grant_a;
      accept  = grant_a || grant_b;
      acc_op  = grant_b ? B_OP  : A_OP;
      acc_arg = grant_b ? B_ARG : A_ARG;
      acc_zero_step = ((acc_op == OP_UP) || (acc_op == OP_DOWN)) && (acc_arg == 4'd0);
   end

   always_comb begin
      clamped  = ({1'b0, cur_arg} > MAX_W);
      load_val = clamped ? MAX_V : cur_arg;
      at_top   = (pos == MAX_V);
      at_bot   = (pos == 4'd0);
   end

   // Next state and strobes. A step ends either when its remaining count runs
   // out or when the strobe just issued lands on the limit, so saturation
   // does not cost an extra idle EXEC cycle.
   always_comb begin
      state_next = state;
      inc_s      = 1'b0;
      dec_s      = 1'b0;
      par_s      = 1'b0;
      clr_s      = 1'b0;
      fin_sat    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = acc_zero_step ? FIN : EXEC;
            end
         end
         EXEC: begin
            case (cur_op)
               OP_CLEAR: begin
                  clr_s      = 1'b1;
                  state_next = FIN;
               end
               OP_LOAD: begin
                  par_s      = 1'b1;
                  fin_sat    = clamped;
                  state_next = FIN;
               end
               OP_UP: begin
                  if ((cur_arg != 4'd0) && !at_top) begin
                     inc_s = 1'b1;
                     if ((cur_arg == 4'd1) || (pos == MAX_M1)) begin
                        state_next = FIN;
                        fin_sat    = (cur_arg != 4'd1);
                     end
                  end else begin
                     state_next = FIN;
                     fin_sat    = (cur_arg != 4'd0);
                  end
               end
               default: begin
                  if ((cur_arg != 4'd0) && !at_bot) begin
                     dec_s = 1'b1;
                     if ((cur_arg == 4'd1) || (pos == 4'd1)) begin
                        state_next = FIN;
                        fin_sat    = (cur_arg != 4'd1);
                     end
                  end else begin
                     state_next = FIN;
                     fin_sat    = (cur_arg != 4'd0);
                  end
               end
            endcase
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command capture; cur_arg doubles as the remaining step count.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         prefer_b <= 1'b0;
         cur_op   <= OP_CLEAR;
         cur_arg  <= 4'd0;
         cur_id   <= 1'b0;
      end else if (accept) begin
         prefer_b <= grant_a;
         cur_op   <= acc_op;
         cur_arg  <= acc_arg;
         cur_id   <= grant_b;
      end else if (inc_s || dec_s) begin
         cur_arg <= cur_arg - 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         sat <= 1'b0;
      end else if (accept) begin
         sat <= 1'b0;
      end else if ((state == EXEC) && (state_next == FIN)) begin
         sat <= fin_sat;
      end
   end

   // Shadow of the external counter: each strobe shows up one cycle later.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         pos <= 4'd0;
      end else if (clr_s) begin
         pos <= 4'd0;
      end else if (par_s) begin
         pos <= load_val;
      end else if (inc_s) begin
         pos <= pos + 4'd1;
      end else if (dec_s) begin
         pos <= pos - 4'd1;
      end
   end

   always_comb begin
      A_READY  = grant_a;
      B_READY  = grant_b;
      increase = inc_s;
      decrease = dec_s;
      parallel = par_s;
      CLR      = clr_s;
      load     = par_s ? load_val : 4'd0;
      POS      = pos;
      BUSY     = (state != IDLE);
      DONE     = (state == FIN);
      DONE_ID  = (state == FIN) && cur_id;
      SAT      = sat;
   end

endmodule

// File: tb/tb_counter_sched.sv
// Directed and random checks of counter_sched against a position/arbitration
// model that works per command, not per FSM state.
module tb_counter_sched;

   localparam int MAX_POS = 15;

   logic       CLK = 1'b0;
   logic       CLR_N;
   logic       A_VALID, B_VALID;
   logic [1:0] A_OP, B_OP;
   logic [3:0] A_ARG, B_ARG;
   logic       A_READY, B_READY;
   logic       increase, decrease, parallel, CLR;
   logic [3:0] load;
   logic [3:0] POS;
   logic       BUSY, DONE, DONE_ID, SAT;

   int passCount = 0;
   int checkCount = 0;
   int modelPos = 0;
   bit modelPreferB = 1'b0;

   counter_sched #(.MAX_POS(MAX_POS)) dut (
      .CLK(CLK), .CLR_N(CLR_N),
      .A_VALID(A_VALID), .B_VALID(B_VALID),
      .A_OP(A_OP), .B_OP(B_OP), .A_ARG(A_ARG), .B_ARG(B_ARG),
      .A_READY(A_READY), .B_READY(B_READY),
      .increase(increase), .decrease(decrease), .parallel(parallel), .CLR(CLR),
      .load(load), .POS(POS),
      .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID), .SAT(SAT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: observed no finish required finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Presents one or two requests in an idle cycle and lets the next edge accept.
   task automatic applyStimulus(input bit driveA, input bit driveB,
                                input logic [1:0] opA, input logic [3:0] argA,
                                input logic [1:0] opB, input logic [3:0] argB,
                                output bit winnerB);
      @(negedge CLK);
      A_VALID = driveA; A_OP = opA; A_ARG = argA;
      B_VALID = driveB; B_OP = opB; B_ARG = argB;
      winnerB = driveB && (!driveA || modelPreferB);
      #1;
      checkOutput("a_ready", 32'(A_READY), 32'(!winnerB));
      checkOutput("b_ready", 32'(B_READY), 32'(winnerB));
      modelPreferB = !winnerB;
      @(posedge CLK);
      #1;
      A_VALID = 1'b0;
      B_VALID = 1'b0;
   endtask

   // Follows one accepted command to completion. Expected strobes are
   // {increase,decrease,parallel,CLR}, issued in the first n cycles after acceptance.
   task automatic expectCommand(input bit reqB, input logic [1:0] op, input logic [3:0] arg);
      int startPos = modelPos;
      int a = int'(arg);
      int n;
      int finalPos;
      int expPos;
      bit expSat;
      bit doneSeen = 1'b0;
      logic [3:0] expStrobe;
      case (op)
         2'b00: begin n = 1; finalPos = 0; expSat = 1'b0; expStrobe = 4'b0001; end
         2'b11: begin
            n = 1;
            finalPos = (a > MAX_POS) ? MAX_POS : a;
            expSat = (a > MAX_POS);
            expStrobe = 4'b0010;
         end
         2'b01: begin
            n = (a < MAX_POS - startPos) ? a : MAX_POS - startPos;
            finalPos = startPos + n;
            expSat = (n < a);
            expStrobe = 4'b1000;
         end
         default: begin
            n = (a < startPos) ? a : startPos;
            finalPos = startPos - n;
            expSat = (n < a);
            expStrobe = 4'b0100;
         end
      endcase
      for (int i = 1; i <= 20 && !doneSeen; i++) begin
         @(negedge CLK);
         checkOutput("strobes", 32'({increase, decrease, parallel, CLR}), 32'((i <= n) ? expStrobe : 4'b0000));
         checkOutput("ready_low", 32'({A_READY, B_READY}), 32'(0));
         checkOutput("busy", 32'(BUSY), 32'(1));
         if (i == 1) checkOutput("sat_cleared", 32'(SAT), 32'(0));
         if (op == 2'b11 && i == 1) checkOutput("load_val", 32'(load), 32'(finalPos));
         if (op == 2'b01 || op == 2'b10) begin
            expPos = (op == 2'b01) ? startPos + (((i - 1) < n) ? (i - 1) : n)
                                   : startPos - (((i - 1) < n) ? (i - 1) : n);
            checkOutput("pos_track", 32'(POS), 32'(expPos));
         end
         if (DONE === 1'b1) begin
            doneSeen = 1'b1;
            if ((op == 2'b01 || op == 2'b10) && a == 0) checkOutput("done_at_t1", 32'(i), 32'(1));
            else checkOutput("done_after_strobes", 32'(i > n), 32'(1));
            checkOutput("done_id", 32'(DONE_ID), 32'(reqB));
            checkOutput("sat", 32'(SAT), 32'(expSat));
            checkOutput("pos_final", 32'(POS), 32'(finalPos));
         end
      end
      if (!doneSeen) checkOutput("done_timeout", 32'(0), 32'(1));
      modelPos = finalPos;
      @(negedge CLK);
      checkOutput("idle_after_fin", 32'({BUSY, DONE, DONE_ID}), 32'(0));
      checkOutput("sat_hold", 32'(SAT), 32'(expSat));
      checkOutput("pos_hold", 32'(POS), 32'(finalPos));
   endtask

   initial begin
      bit w;
      bit useA, useB;
      logic [1:0] rOpA, rOpB;
      logic [3:0] rArgA, rArgB;
      int sel;

      CLR_N = 1'b0;
      A_VALID = 1'b0; B_VALID = 1'b0;
      A_OP = 2'b00; B_OP = 2'b00; A_ARG = 4'd0; B_ARG = 4'd0;
      #12;
      checkOutput("reset_flags",
                  32'({A_READY, B_READY, increase, decrease, parallel, CLR, BUSY, DONE, DONE_ID, SAT}), 32'(0));
      checkOutput("reset_pos", 32'(POS), 32'(0));
      checkOutput("reset_load", 32'(load), 32'(0));
      @(posedge CLK); #2; CLR_N = 1'b1;

      $display("[TB] A step up 3 from reset");
      applyStimulus(1'b1, 1'b0, 2'b01, 4'd3, 2'b00, 4'd0, w);
      expectCommand(w, 2'b01, 4'd3);

      $display("[TB] load 13 then B step up 5 saturates");
      applyStimulus(1'b1, 1'b0, 2'b11, 4'd13, 2'b00, 4'd0, w);
      expectCommand(w, 2'b11, 4'd13);
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 4'd5, w);
      expectCommand(w, 2'b01, 4'd5);

      $display("[TB] contention twice in a row");
      applyStimulus(1'b1, 1'b1, 2'b10, 4'd2, 2'b10, 4'd4, w);
      checkOutput("first_winner", 32'(w), 32'(0));
      expectCommand(w, w ? 2'b10 : 2'b10, w ? 4'd4 : 4'd2);
      applyStimulus(1'b1, 1'b1, 2'b10, 4'd2, 2'b10, 4'd4, w);
      checkOutput("second_winner", 32'(w), 32'(1));
      expectCommand(w, 2'b10, w ? 4'd4 : 4'd2);

      $display("[TB] load 9 then step down 12");
      applyStimulus(1'b1, 1'b0, 2'b11, 4'd9, 2'b00, 4'd0, w);
      expectCommand(w, 2'b11, 4'd9);
      applyStimulus(1'b1, 1'b0, 2'b10, 4'd12, 2'b00, 4'd0, w);
      expectCommand(w, 2'b10, 4'd12);

      $display("[TB] zero-length steps and clear");
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 2'b01, 4'd0, w);
      expectCommand(w, 2'b01, 4'd0);
      applyStimulus(1'b1, 1'b0, 2'b10, 4'd0, 2'b00, 4'd0, w);
      expectCommand(w, 2'b10, 4'd0);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd7, 2'b00, 4'd0, w);
      expectCommand(w, 2'b00, 4'd7);

      $display("[TB] reset during fourth strobe of step up 8");
      applyStimulus(1'b1, 1'b0, 2'b01, 4'd8, 2'b00, 4'd0, w);
      for (int i = 1; i <= 4; i++) begin
         @(negedge CLK);
         checkOutput("pre_reset_inc", 32'(increase), 32'(1));
      end
      #1 CLR_N = 1'b0;
      #1;
      checkOutput("reset_strobes", 32'({increase, decrease, parallel, CLR}), 32'(0));
      checkOutput("reset_mid_pos", 32'(POS), 32'(0));
      checkOutput("reset_mid_flags", 32'({BUSY, DONE, DONE_ID, SAT}), 32'(0));
      modelPos = 0;
      modelPreferB = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         checkOutput("reset_hold", 32'({increase, DONE, BUSY}), 32'(0));
      end
      @(posedge CLK); #2; CLR_N = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'b01, 4'd2, 2'b11, 4'd6, w);
      checkOutput("post_reset_winner", 32'(w), 32'(0));
      expectCommand(w, w ? 2'b11 : 2'b01, w ? 4'd6 : 4'd2);

      $display("[TB] random commands");
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 2));
         useA = (sel != 1);
         useB = (sel != 0);
         rOpA = 2'($urandom); rOpB = 2'($urandom);
         rArgA = 4'($urandom); rArgB = 4'($urandom);
         applyStimulus(useA, useB, rOpA, rArgA, rOpB, rArgB, w);
         expectCommand(w, w ? rOpB : rOpA, w ? rArgB : rArgA);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
